// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants for the CPU front end.
package cpu_pkg;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned FQ_DEPTH = 2;
  localparam int unsigned FQ_CNT_W = $clog2(FQ_DEPTH + 1);

  localparam logic [FQ_CNT_W-1:0] FqFull = FQ_CNT_W'(FQ_DEPTH);

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDiscard
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO holding fetched instruction words ahead of the decoder.
module fetch_queue
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  word_t               push_data_i,
  input  logic                pop_i,
  input  logic                flush_i,
  output word_t               head_o,
  output logic [FQ_CNT_W-1:0] count_o
);

  // Pointers wrap naturally because FQ_DEPTH is a power of two.
  localparam int unsigned PtrW = $clog2(FQ_DEPTH);

  word_t                mem_q [FQ_DEPTH];
  logic [PtrW-1:0]      rd_ptr_q;
  logic [PtrW-1:0]      wr_ptr_q;
  logic [FQ_CNT_W-1:0]  count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(FQ_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: one-outstanding-read memory FSM feeding a 2-entry queue,
// with pc tracking the head instruction and redirect via pc_load.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_increment,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [WORD_W-1:0] i_bus,
  output logic              i_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_data
);

  fetch_state_e        state_q;
  addr_t               pc_q;
  addr_t               fetch_addr_q;
  logic                imem_req_q;
  addr_t               imem_addr_q;

  logic [FQ_CNT_W-1:0] fq_count;
  word_t               fq_head;
  logic                fq_push;
  logic                fq_pop;

  // A redirect suppresses both the push of returning data and any pop.
  assign fq_push = (state_q == StReq) && imem_ack && !pc_load;
  assign fq_pop  = pc_increment && i_valid && !pc_load;

  fetch_queue u_fetch_queue (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fq_push),
    .push_data_i (imem_data),
    .pop_i       (fq_pop),
    .flush_i     (pc_load),
    .head_o      (fq_head),
    .count_o     (fq_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= '0;
    end else begin
      if (pc_load) begin
        pc_q         <= load_addr;
        fetch_addr_q <= load_addr;
      end else if (fq_pop) begin
        pc_q <= pc_q + 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (!pc_load && (fq_count < FqFull)) begin
            state_q     <= StReq;
            imem_req_q  <= 1'b1;
            imem_addr_q <= fetch_addr_q;
          end
        end
        StReq: begin
          if (imem_ack) begin
            state_q    <= StIdle;
            imem_req_q <= 1'b0;
            if (!pc_load) begin
              fetch_addr_q <= fetch_addr_q + 1'b1;
            end
          end else if (pc_load) begin
            // Bus read cannot be withdrawn; wait it out and drop the data.
            state_q <= StDiscard;
          end
        end
        StDiscard: begin
          if (imem_ack) begin
            state_q    <= StIdle;
            imem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= StIdle;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign i_valid   = (fq_count != '0);
  assign i_bus     = fq_head;
  assign pc        = pc_q;
  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomised bench for instruction_fetch against a transaction-level model of the fetch unit.
module tb_instruction_fetch;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_increment;
  logic        pc_load;
  logic [15:0] load_addr;
  logic [15:0] i_bus;
  logic        i_valid;
  logic [15:0] pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC (RESET_PC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_increment (pc_increment),
    .pc_load      (pc_load),
    .load_addr    (load_addr),
    .i_bus        (i_bus),
    .i_valid      (i_valid),
    .pc           (pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data)
  );

  int checks    = 0;
  int failures  = 0;
  int mem_delay = 0;
  int wait_cnt  = 0;
  int ack_count = 0;

  // Model: queue of fetched words, architectural pc, next fetch address and
  // the one read in flight (stale once a redirect has overtaken it).
  logic [15:0] mq[$];
  logic [15:0] m_pc    = RESET_PC;
  logic [15:0] m_fetch = RESET_PC;
  logic [15:0] m_addr  = 16'h0000;
  bit          m_req   = 1'b0;
  bit          m_stale = 1'b0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hA500;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit inc, input bit ld, input logic [15:0] la, input bit r,
                            input bit ack_in);
    bit ack;
    int n;
    ack = ack_in && m_req;
    n   = mq.size();
    if (r) begin
      mq.delete();
      m_pc    = RESET_PC;
      m_fetch = RESET_PC;
      m_addr  = 16'h0000;
      m_req   = 1'b0;
      m_stale = 1'b0;
    end else if (ld) begin
      mq.delete();
      m_pc    = la;
      m_fetch = la;
      if (ack) begin
        m_req   = 1'b0;
        m_stale = 1'b0;
      end else if (m_req) begin
        m_stale = 1'b1;
      end
    end else begin
      if (inc && n > 0) begin
        void'(mq.pop_front());
        m_pc = m_pc + 16'd1;
      end
      if (ack) begin
        if (!m_stale) begin
          mq.push_back(mem_word(m_addr));
          m_fetch = m_fetch + 16'd1;
        end
        m_req   = 1'b0;
        m_stale = 1'b0;
      end else if (!m_req && n < 2) begin
        m_req  = 1'b1;
        m_addr = m_fetch;
      end
    end
  endtask

  task automatic compare_model();
    check("imem_req", {15'b0, imem_req}, {15'b0, m_req});
    if (m_req) check("imem_addr", imem_addr, m_addr);
    check("i_valid", {15'b0, i_valid}, {15'b0, mq.size() != 0});
    if (mq.size() != 0) check("i_bus", i_bus, mq[0]);
    check("pc", pc, m_pc);
  endtask

  // One clock: drive at negedge, memory answers the visible request, model
  // advances at posedge, outputs compared at the following negedge.
  task automatic cycle(input bit inc, input bit ld, input logic [15:0] la, input bit r);
    bit ack;
    rst          = r;
    pc_increment = inc;
    pc_load      = ld;
    load_addr    = la;
    ack          = 1'b0;
    if (r || !imem_req) wait_cnt = mem_delay;
    else if (wait_cnt == 0) ack = 1'b1;
    else wait_cnt--;
    imem_ack  = ack;
    imem_data = ack ? mem_word(imem_addr) : 16'($urandom);
    @(posedge clk);
    if (ack && !r) ack_count++;
    model_step(inc, ld, la, r, ack);
    @(negedge clk);
    compare_model();
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 40; i++) begin
      if (i_valid) break;
      cycle(1'b0, 1'b0, 16'h0, 1'b0);
    end
    check(name, {15'b0, i_valid}, 16'h0001);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    rst          = 1'b1;
    pc_increment = 1'b0;
    pc_load      = 1'b0;
    load_addr    = 16'h0;
    imem_ack     = 1'b0;
    imem_data    = 16'h0;
    @(negedge clk);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    check("rst pc", pc, 16'h0000);
    check("rst i_valid", {15'b0, i_valid}, 16'h0000);
    check("rst imem_req", {15'b0, imem_req}, 16'h0000);
    check("rst imem_addr", imem_addr, 16'h0000);
    check("rst i_bus", i_bus, 16'h0000);

    // Zero-wait memory: first request right after reset release.
    ack_count = 0;
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    check("first req", {15'b0, imem_req}, 16'h0001);
    check("first addr", imem_addr, 16'h0000);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    check("first valid", {15'b0, i_valid}, 16'h0001);
    check("first i_bus", i_bus, 16'hA500);
    check("first pc", pc, 16'h0000);

    // No consumption: queue fills after exactly two reads, then one pop -> one read.
    idle(10);
    check("fill acks", ack_count[15:0], 16'd2);
    check("fill req low", {15'b0, imem_req}, 16'h0000);
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    idle(6);
    check("refill acks", ack_count[15:0], 16'd3);
    check("refill pc", pc, 16'h0001);
    check("refill i_bus", i_bus, 16'hA501);

    // Slow memory, redirect while the read of address 3 is pending.
    mem_delay = 5;
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    check("slow req", {15'b0, imem_req}, 16'h0001);
    check("slow addr", imem_addr, 16'h0003);
    idle(3);
    check("slow addr held", imem_addr, 16'h0003);
    cycle(1'b0, 1'b1, 16'h0040, 1'b0);
    check("load i_valid", {15'b0, i_valid}, 16'h0000);
    check("load pc", pc, 16'h0040);
    check("discard addr", imem_addr, 16'h0003);
    wait_valid("load wait");
    check("load i_bus", i_bus, 16'hA540);
    check("load pc head", pc, 16'h0040);

    // pc and fetch address wrap at the top of the address space.
    mem_delay = 0;
    cycle(1'b0, 1'b1, 16'hFFFF, 1'b0);
    wait_valid("wrap wait");
    check("wrap pc", pc, 16'hFFFF);
    check("wrap i_bus", i_bus, 16'h5AFF);
    idle(6);
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    check("wrapped pc", pc, 16'h0000);
    check("wrapped i_bus", i_bus, 16'hA500);

    // Simultaneous load and increment: load wins.
    cycle(1'b1, 1'b1, 16'h1234, 1'b0);
    check("prio pc", pc, 16'h1234);
    check("prio i_valid", {15'b0, i_valid}, 16'h0000);

    // Reset with a read outstanding.
    mem_delay = 4;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) break;
      cycle(1'b0, 1'b0, 16'h0, 1'b0);
    end
    check("mid req seen", {15'b0, imem_req}, 16'h0001);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    check("mid rst req", {15'b0, imem_req}, 16'h0000);
    check("mid rst pc", pc, 16'h0000);
    check("mid rst i_valid", {15'b0, i_valid}, 16'h0000);
    check("mid rst addr", imem_addr, 16'h0000);
    check("mid rst i_bus", i_bus, 16'h0000);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] la;
      if (i % 250 == 0) mem_delay = $urandom_range(0, 3);
      la = ($urandom_range(0, 7) == 0) ? 16'(16'hFFFD + $urandom_range(0, 3)) : 16'($urandom);
      cycle(($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 4), la,
            ($urandom_range(0, 199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
